// File: rtl/muldiv_types_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_types
// Shared types for the RV32M multiply/divide controller: the M-extension
// funct3 encoding, the controller state encoding and the divider iteration
// count.
// -----------------------------------------------------------------------------
package muldiv_types;

  // M-extension operation select (funct3 of opcode 0110011, funct7 0000001).
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } muldiv_state_t;

  // One quotient bit per iteration.
  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/radix2_divider.sv
// -----------------------------------------------------------------------------
// radix2_divider
// Unsigned restoring divider datapath, one quotient bit per step. Sequencing
// (how many steps, when to stop) belongs to the caller.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture dividend/divisor and clear the partial remainder
//   step       : perform one shift/subtract iteration
//   dividend   : unsigned dividend (captured on load)
//   divisor    : unsigned divisor (captured on load)
//   quotient   : quotient register (valid after 32 steps)
//   remainder  : partial remainder register (valid after 32 steps)
// -----------------------------------------------------------------------------
module radix2_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    // The dividend bits shift out of the top of quo_q into the remainder,
    // while quotient bits shift in at the bottom.
    shifted = {rem_q, quo_q[31]};
    // Since rem_q < dvs_q, shifted < 2*dvs_q, so bit 32 of the difference is
    // exactly the borrow: set means "does not fit, restore".
    diff    = shifted - {1'b0, dvs_q};

    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same pre-edge snapshot. These are ordinary
  // registers (not a memory array), so resetting them costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// EX-stage controller for RV32M. Accepts an M-extension op with forwarded
// operands, runs a fixed-latency multiply or a 32-step radix-2 divide, stalls
// the front of the pipeline while busy and holds the result until EX/MEM loads.
//
// Parameters:
//   MUL_LAT      : stall cycles for any multiply (1..8)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : EX holds a valid M-extension op
//   funct3       : operation select (see m_funct3_t)
//   a, b         : forwarded rs1 / rs2 values
//   ack          : EX/MEM register loads this cycle
//   flush        : kill the in-flight op
//   mult_stall   : multiply in progress
//   divide_stall : divide in progress
//   done         : result is valid
//   result       : product word or quotient/remainder
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_types::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  input  logic        flush,
  output logic        mult_stall,
  output logic        divide_stall,
  output logic        done,
  output logic [31:0] result
);

  muldiv_state_t state_q, state_d;
  m_funct3_t     op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   result_q, result_d;

  // In IDLE the op is decoded straight from the EX inputs so that single-cycle
  // cases (special divides, MUL_LAT = 1) can resolve in the start cycle.
  m_funct3_t   op_cur;
  logic [31:0] a_cur, b_cur;

  assign op_cur = (state_q == S_IDLE) ? m_funct3_t'(funct3) : op_q;
  assign a_cur  = (state_q == S_IDLE) ? a : a_q;
  assign b_cur  = (state_q == S_IDLE) ? b : b_q;

  // ---- decode ----------------------------------------------------------------
  logic is_div_op, signed_div, is_rem_op;
  logic div_by_zero, div_ovf, div_special;
  logic [31:0] special_res;

  assign is_div_op   = op_cur[2];
  assign signed_div  = is_div_op && !op_cur[0];   // DIV, REM
  assign is_rem_op   = op_cur[1];                 // REM, REMU (within divides)
  assign div_by_zero = (b_cur == 32'd0);
  assign div_ovf     = signed_div && (a_cur == 32'h8000_0000) && (b_cur == 32'hFFFF_FFFF);
  assign div_special = is_div_op && (div_by_zero || div_ovf);
  assign special_res = div_by_zero ? (is_rem_op ? a_cur : 32'hFFFF_FFFF)
                                   : (is_rem_op ? 32'd0 : 32'h8000_0000);

  // ---- multiplier ------------------------------------------------------------
  // Operands are sign/zero-extended to 33 bits and further to 64; the low 64
  // bits of the unsigned product are the correct two's-complement product.
  logic        a_sgn, b_sgn;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] mul_res;

  assign a_sgn   = (op_cur == F3_MULH) || (op_cur == F3_MULHSU);
  assign b_sgn   = (op_cur == F3_MULH);
  assign mul_a   = {{32{a_sgn & a_cur[31]}}, a_cur};
  assign mul_b   = {{32{b_sgn & b_cur[31]}}, b_cur};
  assign product = mul_a * mul_b;
  assign mul_res = (op_cur == F3_MUL) ? product[31:0] : product[63:32];

  // ---- divider ---------------------------------------------------------------
  logic        div_load, div_step;
  logic [31:0] div_dividend, div_divisor, div_quo, div_rem;
  logic        q_neg, r_neg;
  logic [31:0] div_res;

  // Magnitudes are taken from the start-cycle operands (the only cycle load
  // is asserted). abs(0x80000000) is 0x80000000 read as unsigned.
  assign div_dividend = (signed_div && a_cur[31]) ? (32'd0 - a_cur) : a_cur;
  assign div_divisor  = (signed_div && b_cur[31]) ? (32'd0 - b_cur) : b_cur;

  radix2_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign fix-up applied in FIX, using the latched operand signs.
  assign q_neg   = signed_div && (a_cur[31] ^ b_cur[31]);
  assign r_neg   = signed_div && a_cur[31];
  assign div_res = is_rem_op ? (r_neg ? (32'd0 - div_rem) : div_rem)
                             : (q_neg ? (32'd0 - div_quo) : div_quo);

  // ---- FSM -------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    div_load     = 1'b0;
    div_step     = 1'b0;
    mult_stall   = 1'b0;
    divide_stall = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d = op_cur;
          a_d  = a;
          b_d  = b;
          if (is_div_op) begin
            divide_stall = 1'b1;
            if (div_special) begin
              state_d  = S_DONE;
              result_d = special_res;
            end else begin
              state_d  = S_DIV;
              cnt_d    = 5'(DIV_ITERS - 1);
              div_load = 1'b1;
            end
          end else begin
            mult_stall = 1'b1;
            if (MUL_LAT == 1) begin
              state_d  = S_DONE;
              result_d = mul_res;
            end else begin
              state_d = S_MUL;
              cnt_d   = 5'(MUL_LAT - 2);
            end
          end
        end
      end

      S_MUL: begin
        mult_stall = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_DIV: begin
        divide_stall = 1'b1;
        div_step     = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_FIX: begin
        divide_stall = 1'b1;
        state_d      = S_DONE;
        result_d     = div_res;
      end

      S_DONE: begin
        // A start seen here is the same instruction still sitting in EX.
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything: abandon the op, keep the old result.
    if (flush) begin
      state_d      = S_IDLE;
      cnt_d        = 5'd0;
      result_d     = result_q;
      div_load     = 1'b0;
      div_step     = 1'b0;
      mult_stall   = 1'b0;
      divide_stall = 1'b0;
    end

    // The start-cycle stall is combinational, so gate it while in reset.
    if (rst) begin
      mult_stall   = 1'b0;
      divide_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= F3_MUL;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl: a table of directed vectors, hand
// sequences for flush / reset / ack hold, and randomized ops compared against
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        ack;
  logic        flush;
  logic        mult_stall, divide_stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_result;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .a            (a),
    .b            (b),
    .ack          (ack),
    .flush        (flush),
    .mult_stall   (mult_stall),
    .divide_stall (divide_stall),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------------
  function automatic logic [31:0] model_result(input logic [2:0] f,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p  = '0;
    case (f)
      3'b000: begin p = sx * sy; return p[31:0];  end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'b101: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
    if (!f[2]) return MUL_LAT;
    if (y == 0) return 1;
    if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // Issue one op at the next falling edge and follow it to done. Inputs stay
  // asserted (as EX would hold them); returns in the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input logic ack_v,
                        input string tag);
    int cyc   = 0;
    int mcnt  = 0;
    int dcnt  = 0;
    bit seen  = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y; ack = ack_v; flush = 1'b0;
    while (!seen && cyc < 100) begin
      #1;
      if (done) begin
        seen = 1;
        check($sformatf("%s latency", tag), 32'(cyc), 32'(lat));
        check($sformatf("%s result", tag), result, exp);
        check($sformatf("%s stall@done", tag), {30'd0, mult_stall, divide_stall}, 32'd0);
        check($sformatf("%s stall cycles", tag), {16'(mcnt), 16'(dcnt)},
              f[2] ? {16'd0, 16'(lat)} : {16'(lat), 16'd0});
      end else begin
        if (mult_stall)   mcnt++;
        if (divide_stall) dcnt++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) check($sformatf("%s timeout", tag), 32'd0, 32'd1);
    prev_result = exp;
  endtask

  // ---- directed vectors ------------------------------------------------------
  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[4]  = '{3'b000, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, MUL_LAT};
    vecs[5]  = '{3'b101, 32'd100,        32'd7,         32'd14,        DIV_LAT};
    vecs[6]  = '{3'b111, 32'd100,        32'd7,         32'd2,         DIV_LAT};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT};
    vecs[8]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT};
    vecs[9]  = '{3'b100, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1};
    vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[11] = '{3'b111, 32'd5,          32'd0,         32'd5,         1};
    vecs[12] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         DIV_LAT};
    vecs[13] = '{3'b100, 32'h8000_0000,  32'd2,         32'hC000_0000, DIV_LAT};

    // ---- reset state, with a multiply presented while reset is high ---------
    rst = 1'b1; start = 1'b0; funct3 = 3'b000; a = '0; b = '0; ack = 1'b1; flush = 1'b0;
    prev_result = '0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 32'd5; b = 32'd6;
    #1;
    check("reset mult_stall", {31'd0, mult_stall}, 32'd0);
    check("reset divide_stall", {31'd0, divide_stall}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // ---- directed table, issued back to back --------------------------------
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].lat, 1'b1,
             $sformatf("vec%0d", i));
    end

    // ---- flush in cycle 10 of a divide --------------------------------------
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd1000; b = 32'd7; ack = 1'b1; flush = 1'b0;
    repeat (9) @(negedge clk);
    #1 check("flush pre divide_stall", {31'd0, divide_stall}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush cycle stalls", {30'd0, mult_stall, divide_stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("post flush stalls", {30'd0, mult_stall, divide_stall}, 32'd0);
    check("post flush done", {31'd0, done}, 32'd0);
    begin
      bit seen_done = 0;
      repeat (40) begin
        @(negedge clk);
        #1 if (done) seen_done = 1;
      end
      check("flush never done", {31'd0, seen_done}, 32'd0);
    end
    check("flush result held", result, prev_result);

    // ---- reset pulsed mid-multiply ------------------------------------------
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd4;
    @(negedge clk);
    #1 check("pre reset mult_stall", {31'd0, mult_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid reset stalls", {30'd0, mult_stall, divide_stall}, 32'd0);
    check("mid reset done", {31'd0, done}, 32'd0);
    check("mid reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    check("after reset done", {31'd0, done}, 32'd0);
    check("after reset result", result, 32'd0);

    // ---- ack held low in DONE with start high, then ack and a new DIVU -------
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0, "hold");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d done", k), {31'd0, done}, 32'd1);
      check($sformatf("hold%0d result", k), result, 32'hFFFF_FFFE);
      check($sformatf("hold%0d stalls", k), {30'd0, mult_stall, divide_stall}, 32'd0);
    end
    @(negedge clk);
    ack = 1'b1;
    #1 check("ack cycle done", {31'd0, done}, 32'd1);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1, "after ack");

    // ---- randomized ops against the reference model -------------------------
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  rf;
      logic [31:0] rx, ry;
      rf = 3'($urandom_range(0, 7));
      rx = pick_operand();
      ry = pick_operand();
      run_op(rf, rx, ry, model_result(rf, rx, ry), model_latency(rf, rx, ry), 1'b1,
             $sformatf("rnd%0d f=%0d a=%h b=%h", n, rf, rx, ry));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end

    @(negedge clk);
    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
